backprop_sequencer: RTL and testbench
=====================================

# backprop_sequencer

Sequencing controller for the `backprop_stack` datapath. It walks layers from last to first and issues the stack's control strobes in a fixed per-layer schedule: load vectors, propagate `dy_dy_old`, copy, stream `dc_dw`, clear. It also generates `current_layer_index` and `dc_dw_layer_index`. It sits between the training top-level, which issues `start` and supplies the backprop vectors, and the `backprop_stack` instance.

## Interface
Parameters:
- `size`, 3: vector length; also the number of load cycles and stream cycles per layer.
- `max_layer_size`, 4: maximum number of layers supported by the stack.

Ports:
- `clk`  in  1  single clock, all logic on posedge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  begin a backprop pass; sampled only in IDLE.
- `num_layers`  in  33  layer count N for this pass; latched on accepted `start`.
- `in_valid`  in  1  backprop_start/to_all/dense vectors on the stack inputs are valid this cycle.
- `in_ready`  out  1  controller consumes one input row this cycle (LOAD state).
- `current_layer_index`  out  33  to stack `current_layer_index`.
- `dc_dw_layer_index`  out  33  to stack `dc_dw_layer_index`.
- `copy`  out  1  to stack `copy`.
- `stack_reset`  out  1  to stack `reset`; clears `dy_dw` of the current layer.
- `cal_dy_dy_old`  out  1  to stack `cal_dy_dy_old`.
- `stream_valid`  out  1  stack `dc_dw_stream` holds a valid row this cycle.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse at the end of the pass.
- `cfg_err`  out  1  one-cycle pulse when `start` is rejected.

## Operation
- States: IDLE, LOAD, PROP, COPY, STREAM, CLEAR, DONE. L is the layer register; `cnt` is a row counter of width clog2(size)+1.
- IDLE:
  - On `start` with 1 ≤ `num_layers` ≤ `max_layer_size`: L ← N−1, `cnt` ← 0, go to LOAD.
  - On `start` with `num_layers` = 0 or > `max_layer_size`: pulse `cfg_err` next cycle and stay in IDLE.
- LOAD:
  - `in_ready` = 1.
  - When `in_valid` = 1: `cnt`++. When `cnt` reaches size−1 with `in_valid` = 1, go to PROP.
  - When `in_valid` = 0: hold `cnt` and the state.
- PROP: `cal_dy_dy_old` = 1 for one cycle → COPY.
- COPY: `copy` = 1 for one cycle; `cnt` ← 0 → STREAM.
- STREAM: `dc_dw_layer_index` = `cnt`. `cnt` counts 0..size−1 unconditionally, then → CLEAR.
- CLEAR: `stack_reset` = 1 for one cycle.
  - If L = 0: go to DONE.
  - Otherwise: L ← L−1, `cnt` ← 0, go to LOAD.
- DONE: `done` = 1 for one cycle → IDLE.
- `current_layer_index` = L (zero-extended to 33 bits) in every non-IDLE state; 0 in IDLE.
- `dc_dw_layer_index` = 0 outside STREAM.
- `stream_valid`: a registered copy of (state == STREAM). It is high in the size cycles following the first STREAM cycle, which covers the stack's one-cycle `dc_dw` register latency. It therefore overlaps CLEAR.
- `start` while `busy` is ignored. `num_layers` changes after acceptance have no effect.
- All strobes (`copy`, `stack_reset`, `cal_dy_dy_old`) are decoded from registered state and are mutually exclusive.

## Timing
- Reset values: state IDLE, L = 0, `cnt` = 0; all outputs 0.
- `reset` asserted in any state returns to IDLE at the next edge. A partial pass is abandoned and no `done` is issued. `stream_valid` drops on that same edge.
- `start` is sampled at edge T; `busy` and LOAD begin at T+1.
- Per-layer cost with `in_valid` held high: size + 1 + 1 + size + 1 = 2·size+3 cycles (9 for size = 3). Each `in_valid` = 0 cycle in LOAD adds one cycle.
- `done` is high exactly N·(2·size+3) cycles after the first LOAD cycle, with no stalls.
- `busy` falls in the cycle after `done`. A new `start` is accepted in that first IDLE cycle.
- `cfg_err` is high in the cycle after the rejected `start`; `busy` stays 0.

## Test plan
- Reset, then N = 2, `in_valid` = 1 constant:
  - `current_layer_index` = 1 for 9 cycles, then 0 for 9 cycles.
  - `done` at cycle 19 after the `start` edge; strobe order per layer is PROP, COPY, STREAM×3, CLEAR.
- N = 1 with `in_valid` pattern 1,0,0,1,1:
  - `in_ready` high for 5 cycles and LOAD lasts 5 cycles.
  - `cal_dy_dy_old` follows the third valid row; `done` lands 2 cycles later than the no-stall case.
- Stream check:
  - `dc_dw_layer_index` = 0,1,2 on consecutive cycles.
  - `stream_valid` high on the 3 cycles each lagging one cycle behind; never high outside that window.
- Config errors:
  - `num_layers` = 0 → `cfg_err` pulse, `busy` = 0.
  - `num_layers` = 5 → `cfg_err` pulse.
  - `num_layers` = 4 → accepted; `current_layer_index` starts at 3.
- `reset` asserted during STREAM of layer 1 (N = 2):
  - Next cycle all outputs are 0 and the state is IDLE; no `done`.
  - A following `start` with N = 1 completes in 9 cycles.
- `start` pulsed repeatedly while `busy`: no effect on the sequence; exactly one `done`.

Source files
------------

// File: rtl/backprop_sequencer.sv
// Layer-by-layer control sequencer for the backprop_stack datapath: walks layers
// from last to first issuing load / propagate / copy / stream / clear strobes.
module backprop_sequencer #(
    parameter int size           = 3,
    parameter int max_layer_size = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [32:0] num_layers,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [32:0] current_layer_index,
    output logic [32:0] dc_dw_layer_index,
    output logic        copy,
    output logic        stack_reset,
    output logic        cal_dy_dy_old,
    output logic        stream_valid,
    output logic        busy,
    output logic        done,
    output logic        cfg_err
);

    localparam int          CW       = $clog2(size) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(size - 1);
    localparam logic [32:0] MAX_N    = 33'(max_layer_size);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_PROP, S_COPY, S_STREAM, S_CLEAR, S_DONE
    } state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [32:0]   r_layer;
    logic [CW-1:0] r_cnt;
    logic          r_stream_valid;
    logic          r_cfg_err;
    logic          w_n_ok;
    logic          w_cnt_last;

    assign w_n_ok     = (num_layers != 33'd0) && (num_layers <= MAX_N);
    assign w_cnt_last = (r_cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (start && w_n_ok) w_state_next = S_LOAD;
            S_LOAD:   if (in_valid && w_cnt_last) w_state_next = S_PROP;
            S_PROP:   w_state_next = S_COPY;
            S_COPY:   w_state_next = S_STREAM;
            S_STREAM: if (w_cnt_last) w_state_next = S_CLEAR;
            S_CLEAR:  w_state_next = (r_layer == 33'd0) ? S_DONE : S_LOAD;
            S_DONE:   w_state_next = S_IDLE;
            default:  w_state_next = S_IDLE;
        endcase
    end

    // Layer register, row counter and the two registered pulse outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_layer        <= 33'd0;
            r_cnt          <= '0;
            r_stream_valid <= 1'b0;
            r_cfg_err      <= 1'b0;
        end else begin
            r_stream_valid <= (r_state == S_STREAM);
            r_cfg_err      <= (r_state == S_IDLE) && start && !w_n_ok;
            case (r_state)
                S_IDLE: begin
                    if (start && w_n_ok) begin
                        r_layer <= num_layers - 33'd1;
                        r_cnt   <= '0;
                    end
                end
                S_LOAD: begin
                    if (in_valid) r_cnt <= r_cnt + CW'(1);
                end
                S_COPY:   r_cnt <= '0;
                S_STREAM: r_cnt <= r_cnt + CW'(1);
                S_CLEAR: begin
                    if (r_layer != 33'd0) begin
                        r_layer <= r_layer - 33'd1;
                        r_cnt   <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        in_ready            = 1'b0;
        current_layer_index = 33'd0;
        dc_dw_layer_index   = 33'd0;
        copy                = 1'b0;
        stack_reset         = 1'b0;
        cal_dy_dy_old       = 1'b0;
        busy                = (r_state != S_IDLE);
        done                = 1'b0;
        if (r_state != S_IDLE) current_layer_index = r_layer;
        case (r_state)
            S_LOAD:   in_ready = 1'b1;
            S_PROP:   cal_dy_dy_old = 1'b1;
            S_COPY:   copy = 1'b1;
            S_STREAM: dc_dw_layer_index = {{(33-CW){1'b0}}, r_cnt};
            S_CLEAR:  stack_reset = 1'b1;
            S_DONE:   done = 1'b1;
            default: ;
        endcase
    end

    assign stream_valid = r_stream_valid;
    assign cfg_err      = r_cfg_err;

endmodule

// File: tb/tb_backprop_sequencer.sv
// Randomized bench: builds a cycle-by-cycle expected trace from the per-layer
// schedule rules, drives it into backprop_sequencer and compares every output.
module tb_backprop_sequencer;

    localparam int SIZE = 3;
    localparam int MAXL = 4;

    localparam int P_IDLE   = 0;
    localparam int P_LOAD   = 1;
    localparam int P_PROP   = 2;
    localparam int P_COPY   = 3;
    localparam int P_STREAM = 4;
    localparam int P_CLEAR  = 5;
    localparam int P_DONE   = 6;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [32:0] num_layers;
    logic        in_valid;
    logic        in_ready;
    logic [32:0] current_layer_index;
    logic [32:0] dc_dw_layer_index;
    logic        copy;
    logic        stack_reset;
    logic        cal_dy_dy_old;
    logic        stream_valid;
    logic        busy;
    logic        done;
    logic        cfg_err;

    always #5 clk = ~clk;

    backprop_sequencer #(.size(SIZE), .max_layer_size(MAXL)) dut (
        .clk                 (clk),
        .reset               (reset),
        .start               (start),
        .num_layers          (num_layers),
        .in_valid            (in_valid),
        .in_ready            (in_ready),
        .current_layer_index (current_layer_index),
        .dc_dw_layer_index   (dc_dw_layer_index),
        .copy                (copy),
        .stack_reset         (stack_reset),
        .cal_dy_dy_old       (cal_dy_dy_old),
        .stream_valid        (stream_valid),
        .busy                (busy),
        .done                (done),
        .cfg_err             (cfg_err)
    );

    // One entry per clock cycle: inputs to drive at the end of the cycle and
    // the outputs expected during it.
    typedef struct {
        bit          rst;
        bit          st;
        bit          iv;
        logic [32:0] nl;
        int          ph;
        logic [32:0] cur;
        logic [32:0] dc;
        bit          ce;
        bit          sv;
    } cyc_t;

    cyc_t tr[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc      = 0;
    int   n_passes = 0;

    task automatic check_eq(input string tag, input logic [32:0] obs, input logic [32:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic cyc_t mk(input int ph, input int cur, input int dc);
        cyc_t c;
        c.rst = 1'b0;
        c.st  = (ph != P_IDLE) ? 1'($urandom_range(0, 1)) : 1'b0;
        c.iv  = 1'($urandom_range(0, 1));
        c.nl  = {1'($urandom_range(0, 1)), 32'($urandom())};
        c.ph  = ph;
        c.cur = 33'(cur);
        c.dc  = 33'(dc);
        c.ce  = 1'b0;
        c.sv  = 1'b0;
        return c;
    endfunction

    // abort_mode: 0 none, 1 reset in first STREAM cycle of layer 1, 2 reset at a random busy cycle
    task automatic add_pass(input logic [32:0] n, input int valid_pct, input int abort_mode);
        int   base;
        int   idx;
        int   rows;
        cyc_t c;
        base = tr.size();
        c = mk(P_IDLE, 0, 0);
        c.st = 1'b1;
        c.nl = n;
        tr.push_back(c);
        if (n == 33'd0 || n > 33'(MAXL)) begin
            c = mk(P_IDLE, 0, 0);
            c.ce = 1'b1;
            tr.push_back(c);
            return;
        end
        for (int l = int'(n) - 1; l >= 0; l--) begin
            rows = 0;
            while (rows < SIZE) begin
                c = mk(P_LOAD, l, 0);
                c.iv = ($urandom_range(1, 100) <= valid_pct);
                if (c.iv) rows++;
                tr.push_back(c);
            end
            tr.push_back(mk(P_PROP, l, 0));
            tr.push_back(mk(P_COPY, l, 0));
            for (int j = 0; j < SIZE; j++) tr.push_back(mk(P_STREAM, l, j));
            tr.push_back(mk(P_CLEAR, l, 0));
        end
        tr.push_back(mk(P_DONE, 0, 0));
        if (abort_mode != 0) begin
            idx = tr.size() - 1;
            if (abort_mode == 1) begin
                for (int k = tr.size() - 1; k > base; k--)
                    if (tr[k].ph == P_STREAM && tr[k].cur == 33'd1) idx = k;
            end else begin
                idx = $urandom_range(base + 1, tr.size() - 1);
            end
            while (tr.size() > idx + 1) void'(tr.pop_back());
            tr[idx].rst = 1'b1;
            tr[idx].st  = 1'b0;
        end
    endtask

    task automatic check_outputs(input cyc_t e);
        check_eq("in_ready",      33'(in_ready),      33'(e.ph == P_LOAD));
        check_eq("cur_layer_idx", current_layer_index, e.cur);
        check_eq("dc_dw_idx",     dc_dw_layer_index,   e.dc);
        check_eq("copy",          33'(copy),          33'(e.ph == P_COPY));
        check_eq("stack_reset",   33'(stack_reset),   33'(e.ph == P_CLEAR));
        check_eq("cal_dy_dy_old", 33'(cal_dy_dy_old), 33'(e.ph == P_PROP));
        check_eq("stream_valid",  33'(stream_valid),  33'(e.sv));
        check_eq("busy",          33'(busy),          33'(e.ph != P_IDLE));
        check_eq("done",          33'(done),          33'(e.ph == P_DONE));
        check_eq("cfg_err",       33'(cfg_err),       33'(e.ce));
    endtask

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        in_valid   = 1'b0;
        num_layers = 33'd0;

        add_pass(33'd2, 100, 0);
        add_pass(33'd1, 60, 0);
        add_pass(33'd0, 100, 0);
        add_pass(33'd5, 100, 0);
        add_pass({1'b1, 32'd1}, 100, 0);
        add_pass(33'd4, 100, 0);
        add_pass(33'd2, 100, 1);
        add_pass(33'd1, 100, 0);
        for (int p = 0; p < 30; p++)
            add_pass(33'($urandom_range(0, 6)), $urandom_range(30, 100),
                     ($urandom_range(0, 4) == 0) ? 2 : 0);
        for (int k = 0; k < 3; k++) tr.push_back(mk(P_IDLE, 0, 0));

        // stream_valid is the STREAM phase delayed one cycle, killed by reset
        for (int k = 1; k < tr.size(); k++)
            tr[k].sv = (tr[k-1].ph == P_STREAM) && !tr[k-1].rst;

        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        cyc   = -1;
        check_outputs(mk(P_IDLE, 0, 0));

        for (int k = 0; k < tr.size(); k++) begin
            cyc = k;
            check_outputs(tr[k]);
            if (tr[k].ph == P_IDLE && tr[k].st) begin
                n_passes++;
                $display("cyc %0d: start pass %0d num_layers=%0h", k, n_passes, tr[k].nl);
            end
            if (tr[k].rst) $display("cyc %0d: reset asserted mid-pass", k);
            if (tr[k].ph == P_DONE) $display("cyc %0d: pass done", k);
            reset      = tr[k].rst;
            start      = tr[k].st;
            num_layers = tr[k].nl;
            in_valid   = tr[k].iv;
            @(posedge clk);
            #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
